// File: rtl/hwpe_ctrl_uloop_issuer.sv
// hwpe_ctrl_uloop_issuer: steps the uloop one iteration at a time and issues
// base+offset addresses on independent per-stream valid/ready channels.
module hwpe_ctrl_uloop_issuer #(
   parameter int NB_STREAMS = 4,
   parameter int NB_REG     = 5,
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   clear_i,
   input  logic                                   start_i,
   input  logic [NB_STREAMS-1:0]                  stream_en_i,
   input  logic [NB_STREAMS*ADDR_WIDTH-1:0]       base_addr_i,
   input  logic [NB_STREAMS*$clog2(NB_REG)-1:0]   offs_sel_i,
   output logic                                   uloop_clear_o,
   output logic                                   uloop_enable_o,
   input  logic                                   uloop_valid_i,
   input  logic                                   uloop_done_i,
   input  logic [NB_REG*REG_WIDTH-1:0]            uloop_offs_i,
   output logic [NB_STREAMS-1:0]                  addr_valid_o,
   input  logic [NB_STREAMS-1:0]                  addr_ready_i,
   output logic [NB_STREAMS*ADDR_WIDTH-1:0]       addr_o,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic [CNT_WIDTH-1:0]                   iter_cnt_o
);
   localparam int SW = $clog2(NB_REG);
   localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, REQ = 3'd2, WAIT = 3'd3, FINISH = 3'd4;
   logic [2:0]                       state_q;
   logic [NB_STREAMS-1:0]            en_q, pending_q, pend_nxt;
   logic [NB_STREAMS*ADDR_WIDTH-1:0] base_q;
   logic [NB_STREAMS*SW-1:0]         sel_q;
   logic [REG_WIDTH-1:0]             offs_q [NB_REG];
   logic                             last_q, uclr_q;
   logic [CNT_WIDTH-1:0]             iter_q;
   assign pend_nxt       = pending_q & ~addr_ready_i;
   assign addr_valid_o   = pending_q;
   assign uloop_clear_o  = uclr_q;
   assign uloop_enable_o = state_q == REQ;
   assign busy_o         = state_q != IDLE;
   assign done_o         = state_q == FINISH;
   assign iter_cnt_o     = iter_q;
   // addresses are a pure function of registered state, so they hold while valid
   for (genvar i = 0; i < NB_STREAMS; i++) begin : g_addr
      logic [SW-1:0]        sel;
      logic [REG_WIDTH-1:0] offs;
      assign sel  = sel_q[i*SW +: SW];
      assign offs = (32'(sel) < NB_REG) ? offs_q[sel] : '0;
      assign addr_o[i*ADDR_WIDTH +: ADDR_WIDTH] = base_q[i*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(offs);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         en_q      <= '0;
         pending_q <= '0;
         base_q    <= '0;
         sel_q     <= '0;
         last_q    <= 1'b0;
         uclr_q    <= 1'b0;
         iter_q    <= '0;
         for (int r = 0; r < NB_REG; r++) offs_q[r] <= '0;
      end else if (clear_i) begin
         state_q   <= IDLE;
         pending_q <= '0;
         iter_q    <= '0;
         uclr_q    <= 1'b1;
      end else begin
         uclr_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               en_q      <= stream_en_i;
               base_q    <= base_addr_i;
               sel_q     <= offs_sel_i;
               pending_q <= stream_en_i;
               last_q    <= 1'b0;
               iter_q    <= '0;
               uclr_q    <= 1'b1;
               state_q   <= ISSUE;
               for (int r = 0; r < NB_REG; r++) offs_q[r] <= '0;
            end
            ISSUE: begin
               pending_q <= pend_nxt;
               if (pend_nxt == '0) begin
                  iter_q  <= iter_q + 1'b1;
                  state_q <= last_q ? FINISH : REQ;
               end
            end
            REQ: state_q <= WAIT;
            WAIT: if (uloop_valid_i) begin
               for (int r = 0; r < NB_REG; r++) offs_q[r] <= uloop_offs_i[r*REG_WIDTH +: REG_WIDTH];
               last_q    <= uloop_done_i;
               pending_q <= en_q;
               state_q   <= ISSUE;
            end else if (uloop_done_i) state_q <= FINISH;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
